// File: rtl/gfx256_render_wbm.sv
// Write-combining responder for the renderer pixel port. Byte writes to one 32-byte line merge
// in a single line buffer that is written back over a 256-bit Wishbone master.
module gfx256_render_wbm #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TW      = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  render_addr_i,
  input  logic [31:0]  render_sel_i,
  input  logic [255:0] render_dat_i,
  input  logic         write_i,
  input  logic         read_i,
  output logic         ack_o,
  output logic [255:0] render_dat_o,
  input  logic         flush_i,
  output logic         idle_o,
  output logic         wb_cyc_o,
  output logic         wb_stb_o,
  output logic         wb_we_o,
  output logic [31:0]  wb_sel_o,
  output logic [31:0]  wb_adr_o,
  output logic [255:0] wb_dat_o,
  input  logic         wb_ack_i,
  input  logic [255:0] wb_dat_i
);

  typedef enum logic [1:0] {StIdle, StAck, StFlush, StRead} state_e;

  localparam logic [TW-1:0] TimeoutCnt = TW'(TIMEOUT);

  state_e         state_q;
  logic [26:0]    tag_q;
  logic [255:0]   data_q;
  logic [31:0]    mask_q;
  logic           valid_q;
  logic [TW-1:0]  cnt_q;

  logic           hit;
  logic           timeout_hit;
  logic           flush_go;
  logic [255:0]   merged;
  logic           unused_addr;

  assign unused_addr = ^render_addr_i[4:0];
  assign hit         = valid_q && (tag_q == render_addr_i[31:5]);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TimeoutCnt);

  // Requests outrank flush_i and the timeout; a read hit must write back before re-reading.
  assign flush_go = (write_i && valid_q && !hit) ||
                    (!write_i && read_i && hit) ||
                    (!write_i && !read_i && valid_q && (flush_i || timeout_hit));

  assign idle_o = !rst_i && (state_q == StIdle) && !valid_q && !write_i && !read_i;

  always_comb begin
    merged = data_q;
    for (int b = 0; b < 32; b++) begin
      if (render_sel_i[b]) merged[b*8 +: 8] = render_dat_i[b*8 +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      tag_q        <= '0;
      data_q       <= '0;
      mask_q       <= '0;
      valid_q      <= 1'b0;
      cnt_q        <= '0;
      ack_o        <= 1'b0;
      render_dat_o <= '0;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_sel_o     <= '0;
      wb_adr_o     <= '0;
      wb_dat_o     <= '0;
    end else begin
      ack_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (flush_go) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= 1'b1;
            wb_adr_o <= {tag_q, 5'b0};
            wb_sel_o <= mask_q;
            wb_dat_o <= data_q;
            cnt_q    <= '0;
            state_q  <= StFlush;
          end else if (write_i) begin
            // Empty or hit: merge enabled bytes; a zero select is acked without touching state.
            if (render_sel_i != '0) begin
              data_q  <= merged;
              mask_q  <= mask_q | render_sel_i;
              tag_q   <= render_addr_i[31:5];
              valid_q <= 1'b1;
              cnt_q   <= '0;
            end
            ack_o   <= 1'b1;
            state_q <= StAck;
          end else if (read_i) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= 1'b0;
            wb_sel_o <= '1;
            wb_adr_o <= {render_addr_i[31:5], 5'b0};
            state_q  <= StRead;
          end else if (valid_q && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        // Renderer changes addr/data on this edge, so requests are not looked at here.
        StAck: state_q <= StIdle;
        StFlush: begin
          if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            valid_q  <= 1'b0;
            mask_q   <= '0;
            cnt_q    <= '0;
            state_q  <= StIdle;
          end
        end
        StRead: begin
          if (wb_ack_i) begin
            render_dat_o <= wb_dat_i;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            ack_o        <= 1'b1;
            state_q      <= StAck;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_gfx256_render_wbm.sv
// Bench for gfx256_render_wbm: a Wishbone memory slave plus a coherent byte-memory reference
// model; every renderer write lands in the model immediately, so bus memory must match it.
module tb_gfx256_render_wbm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic [31:0]  render_addr = '0, render_sel = '0;
  logic [255:0] render_dat = '0;
  logic         write = 1'b0, read = 1'b0, flush = 1'b0;
  logic         ack, idle;
  logic [255:0] rdat;
  logic         wb_cyc, wb_stb, wb_we;
  logic [31:0]  wb_sel, wb_adr;
  logic [255:0] wb_dat_o;
  logic         wb_ack = 1'b0;
  logic [255:0] wb_dat_i = '0;

  // Second instance with the timeout disabled.
  logic [31:0]  n_addr = '0, n_sel = '0;
  logic [255:0] n_dat = '0;
  logic         n_write = 1'b0;
  logic         n_ack, n_idle, n_cyc, n_stb, n_we;
  logic [255:0] n_rdat, n_wdat;
  logic [31:0]  n_wsel, n_wadr;

  gfx256_render_wbm #(.TIMEOUT(16), .TW(8)) dut (
    .clk_i(clk), .rst_i(rst), .render_addr_i(render_addr), .render_sel_i(render_sel),
    .render_dat_i(render_dat), .write_i(write), .read_i(read), .ack_o(ack),
    .render_dat_o(rdat), .flush_i(flush), .idle_o(idle), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb),
    .wb_we_o(wb_we), .wb_sel_o(wb_sel), .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o),
    .wb_ack_i(wb_ack), .wb_dat_i(wb_dat_i)
  );

  gfx256_render_wbm #(.TIMEOUT(0), .TW(8)) dut_nt (
    .clk_i(clk), .rst_i(rst), .render_addr_i(n_addr), .render_sel_i(n_sel),
    .render_dat_i(n_dat), .write_i(n_write), .read_i(1'b0), .ack_o(n_ack),
    .render_dat_o(n_rdat), .flush_i(1'b0), .idle_o(n_idle), .wb_cyc_o(n_cyc), .wb_stb_o(n_stb),
    .wb_we_o(n_we), .wb_sel_o(n_wsel), .wb_adr_o(n_wadr), .wb_dat_o(n_wdat),
    .wb_ack_i(1'b0), .wb_dat_i(256'h0)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] sel;
    logic [255:0] dat;
    int          cyc;
  } bus_t;

  bus_t         blog[$];
  logic [255:0] bus_mem[int unsigned];
  logic [255:0] ref_mem[int unsigned];

  int checks = 0, failures = 0;
  int cycle = 0, ack_cnt = 0, last_ack_cyc = 0;
  int ack_delay = 0, wait_cnt = 0, stab_err = 0;
  bit withhold = 1'b0, held = 1'b0;
  logic [320:0] held_sig;
  int unsigned  slv_line;
  logic [255:0] slv_cur;

  function automatic logic [255:0] init_line(int unsigned line);
    return {8{line ^ 32'h5a5a_0000}};
  endfunction

  function automatic logic [255:0] ref_line(int unsigned line);
    return ref_mem.exists(line) ? ref_mem[line] : init_line(line);
  endfunction

  function automatic logic [255:0] mem_line(int unsigned line);
    return bus_mem.exists(line) ? bus_mem[line] : init_line(line);
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] s, input logic [255:0] d);
    logic [255:0] cur;
    cur = ref_line(a >> 5);
    for (int b = 0; b < 32; b++) if (s[b]) cur[b*8 +: 8] = d[b*8 +: 8];
    ref_mem[a >> 5] = cur;
  endtask

  always @(posedge clk) cycle <= cycle + 1;

  // Wishbone memory slave, acks after ack_delay wait cycles, also watches bus stability.
  always @(negedge clk) begin
    if (ack === 1'b1) ack_cnt++;
    if (rst) begin
      wb_ack = 1'b0; wait_cnt = 0; held = 1'b0;
    end else if (wb_ack) begin
      wb_ack = 1'b0;
    end else if (wb_cyc && wb_stb) begin
      if (held && ({wb_we, wb_adr, wb_sel, wb_dat_o} !== held_sig)) stab_err++;
      held = 1'b1;
      held_sig = {wb_we, wb_adr, wb_sel, wb_dat_o};
      if (!withhold && wait_cnt >= ack_delay) begin
        slv_line = wb_adr >> 5;
        slv_cur = mem_line(slv_line);
        if (wb_we) begin
          for (int b = 0; b < 32; b++) if (wb_sel[b]) slv_cur[b*8 +: 8] = wb_dat_o[b*8 +: 8];
          bus_mem[slv_line] = slv_cur;
        end else begin
          wb_dat_i = slv_cur;
        end
        blog.push_back('{wb_we, wb_adr, wb_sel, wb_dat_o, cycle});
        wb_ack = 1'b1; wait_cnt = 0; held = 1'b0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0; held = 1'b0;
    end
  end

  task automatic do_req(input bit we, input bit rd, input logic [31:0] a, input logic [31:0] s,
                        input logic [255:0] d, input bit upd, output logic [255:0] rdata);
    int n;
    @(negedge clk);
    render_addr = a; render_sel = s; render_dat = d; write = we; read = rd;
    n = 0;
    while (ack !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (ack !== 1'b1) begin
      failures++;
      $display("FAIL req_ack addr=%h: ack_o=%b after %0d cycles, required 1", a, ack, n);
    end
    rdata = rdat;
    last_ack_cyc = cycle;
    write = 1'b0; read = 1'b0;
    if (upd && we) ref_write(a, s, d);
  endtask

  task automatic drain();
    int n;
    n = 0;
    flush = 1'b1;
    @(negedge clk);
    while (!(idle === 1'b1 && wb_cyc === 1'b0) && n < 200) begin @(negedge clk); n++; end
    flush = 1'b0;
    checks++;
    if (idle !== 1'b1) begin
      failures++;
      $display("FAIL drain: idle_o=%b, required 1", idle);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (ack !== 1'b0 || idle !== 1'b0) begin
      failures++; $display("FAIL reset_ack_idle: ack_o=%b idle_o=%b, required 0 0", ack, idle);
    end
    checks++;
    if ({wb_cyc, wb_stb, wb_we} !== 3'b000) begin
      failures++; $display("FAIL reset_bus_ctl: cyc/stb/we=%b, required 000", {wb_cyc, wb_stb, wb_we});
    end
    checks++;
    if (wb_sel !== 32'h0 || wb_adr !== 32'h0 || wb_dat_o !== 256'h0 || rdat !== 256'h0) begin
      failures++;
      $display("FAIL reset_data: sel=%h adr=%h, required 0 and zero data", wb_sel, wb_adr);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (idle !== 1'b1) begin
      failures++; $display("FAIL reset_idle: idle_o=%b, required 1", idle);
    end
  endtask

  task automatic test_merge_flush();
    logic [255:0] d1, d2, rd;
    int a0, n;
    drain(); blog.delete();
    do_req(1'b1, 1'b0, 32'h1000, 32'h0, rand256(), 1'b1, rd);
    @(negedge clk);
    checks++;
    if (idle !== 1'b1) begin
      failures++; $display("FAIL sel_zero_idle: idle_o=%b, required 1", idle);
    end
    d1 = rand256(); d2 = rand256();
    a0 = ack_cnt;
    do_req(1'b1, 1'b0, 32'h1000, 32'h0000_000f, d1, 1'b1, rd);
    do_req(1'b1, 1'b0, 32'h1004, 32'h0000_00f0, d2, 1'b1, rd);
    repeat (2) @(negedge clk);
    checks++;
    if (ack_cnt - a0 !== 2 || blog.size() !== 0) begin
      failures++;
      $display("FAIL merge_acks: acks=%0d bus=%0d, required 2 0", ack_cnt - a0, blog.size());
    end
    flush = 1'b1;
    n = 0;
    while (blog.size() == 0 && n < 50) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    flush = 1'b0;
    checks++;
    if (blog.size() !== 1) begin
      failures++; $display("FAIL flush_count: bus cycles=%0d, required 1", blog.size());
    end else begin
      checks++;
      if (blog[0].we !== 1'b1 || blog[0].adr !== 32'h1000 || blog[0].sel !== 32'h0000_00ff) begin
        failures++;
        $display("FAIL flush_hdr: we=%b adr=%h sel=%h, required 1 00001000 000000ff",
                 blog[0].we, blog[0].adr, blog[0].sel);
      end
      checks++;
      if (blog[0].dat[63:0] !== {d2[63:32], d1[31:0]}) begin
        failures++;
        $display("FAIL flush_data: %h, required %h", blog[0].dat[63:0], {d2[63:32], d1[31:0]});
      end
    end
  endtask

  task automatic test_line_miss();
    logic [255:0] d1, d2, rd;
    drain(); blog.delete();
    d1 = rand256(); d2 = rand256();
    do_req(1'b1, 1'b0, 32'h1000, 32'h1, d1, 1'b1, rd);
    do_req(1'b1, 1'b0, 32'h2000, 32'h3, d2, 1'b1, rd);
    checks++;
    if (blog.size() !== 1) begin
      failures++; $display("FAIL miss_flush: bus cycles=%0d, required 1", blog.size());
    end else begin
      checks++;
      if (blog[0].adr !== 32'h1000 || blog[0].sel !== 32'h1 || blog[0].dat[7:0] !== d1[7:0]) begin
        failures++;
        $display("FAIL miss_wr: adr=%h sel=%h, required 00001000 00000001", blog[0].adr, blog[0].sel);
      end
      checks++;
      if (!(blog[0].cyc < last_ack_cyc)) begin
        failures++;
        $display("FAIL miss_order: bus at %0d ack at %0d, required bus earlier", blog[0].cyc,
                 last_ack_cyc);
      end
    end
    drain();
    checks++;
    if (blog.size() !== 2 || blog[blog.size()-1].adr !== 32'h2000 ||
        blog[blog.size()-1].dat[15:0] !== d2[15:0]) begin
      failures++;
      $display("FAIL miss_newtag: cycles=%0d, required 2 with last at 00002000", blog.size());
    end
  endtask

  task automatic test_read_hit();
    logic [255:0] d1, rd;
    logic [31:0]  s;
    drain(); blog.delete();
    ack_delay = 2;
    d1 = rand256(); s = $urandom | 32'h1;
    do_req(1'b1, 1'b0, 32'h3000, s, d1, 1'b1, rd);
    do_req(1'b0, 1'b1, 32'h3008, 32'h0, 256'h0, 1'b1, rd);
    checks++;
    if (blog.size() !== 2) begin
      failures++; $display("FAIL rdhit_count: bus cycles=%0d, required 2", blog.size());
    end else begin
      checks++;
      if (blog[0].we !== 1'b1 || blog[0].adr !== 32'h3000 || blog[0].sel !== s) begin
        failures++;
        $display("FAIL rdhit_flush: we=%b adr=%h sel=%h, required 1 00003000 %h", blog[0].we,
                 blog[0].adr, blog[0].sel, s);
      end
      checks++;
      if (blog[1].we !== 1'b0 || blog[1].adr !== 32'h3000 || blog[1].sel !== 32'hffff_ffff) begin
        failures++;
        $display("FAIL rdhit_read: we=%b adr=%h sel=%h, required 0 00003000 ffffffff",
                 blog[1].we, blog[1].adr, blog[1].sel);
      end
    end
    checks++;
    if (rd !== ref_line(32'h3000 >> 5)) begin
      failures++; $display("FAIL rdhit_data: %h, required %h", rd, ref_line(32'h3000 >> 5));
    end
    ack_delay = 0;
  endtask

  task automatic test_timeout();
    logic [255:0] rd;
    int n;
    drain(); blog.delete();
    do_req(1'b1, 1'b0, 32'h5000, 32'hff, rand256(), 1'b1, rd);
    n = 0;
    @(negedge clk);
    while (wb_cyc !== 1'b1 && n < 100) begin n++; @(negedge clk); end
    checks++;
    if (n !== 17) begin
      failures++; $display("FAIL timeout_delay: idle cycles=%0d, required 17", n);
    end
    checks++;
    if (wb_we !== 1'b1 || wb_adr !== 32'h5000) begin
      failures++; $display("FAIL timeout_wr: we=%b adr=%h, required 1 00005000", wb_we, wb_adr);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout_disabled();
    int n;
    bit seen;
    @(negedge clk);
    n_addr = 32'h5000; n_sel = 32'hf; n_dat = rand256(); n_write = 1'b1;
    n = 0;
    while (n_ack !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    n_write = 1'b0;
    checks++;
    if (n_ack !== 1'b1) begin
      failures++; $display("FAIL nt_ack: ack_o=%b, required 1", n_ack);
    end
    seen = 1'b0;
    repeat (60) begin @(negedge clk); if (n_cyc !== 1'b0) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0 || n_idle !== 1'b0) begin
      failures++; $display("FAIL nt_noflush: cyc seen=%b idle_o=%b, required 0 0", seen, n_idle);
    end
  endtask

  task automatic test_renderer_seq();
    logic [255:0] dp, dz;
    int a0, n;
    drain(); blog.delete();
    ack_delay = 3;
    dp = rand256(); dz = rand256();
    a0 = ack_cnt;
    @(negedge clk);
    render_addr = 32'h6010; render_sel = 32'h000f_0000; render_dat = dp; write = 1'b1;
    n = 0;
    while (ack !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (ack !== 1'b1) begin failures++; $display("FAIL seq_pix_ack: ack_o=%b, required 1", ack); end
    render_addr = 32'h9000; render_sel = 32'h0000_000f; render_dat = dz;
    @(negedge clk);
    n = 0;
    while (ack !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (ack !== 1'b1) begin failures++; $display("FAIL seq_z_ack: ack_o=%b, required 1", ack); end
    write = 1'b0;
    ref_write(32'h6010, 32'h000f_0000, dp);
    ref_write(32'h9000, 32'h0000_000f, dz);
    repeat (8) @(negedge clk);
    checks++;
    if (ack_cnt - a0 !== 2) begin
      failures++; $display("FAIL seq_acks: acks=%0d, required 2", ack_cnt - a0);
    end
    drain();
    checks++;
    if (blog.size() !== 2) begin
      failures++; $display("FAIL seq_count: bus cycles=%0d, required 2", blog.size());
    end else begin
      checks++;
      if (blog[0].adr !== 32'h6000 || blog[1].adr !== 32'h9000 || blog[1].sel !== 32'hf ||
          blog[1].dat[31:0] !== dz[31:0]) begin
        failures++;
        $display("FAIL seq_lines: adr0=%h adr1=%h sel1=%h, required 00006000 00009000 0000000f",
                 blog[0].adr, blog[1].adr, blog[1].sel);
      end
    end
    ack_delay = 0;
  endtask

  task automatic test_priority();
    logic [255:0] rd;
    drain(); blog.delete();
    do_req(1'b1, 1'b1, 32'ha000, 32'h00ff_0000, rand256(), 1'b1, rd);
    @(negedge clk);
    checks++;
    if (blog.size() !== 0 || idle !== 1'b0) begin
      failures++;
      $display("FAIL prio_write: bus=%0d idle_o=%b, required 0 0", blog.size(), idle);
    end
    drain();
    checks++;
    if (blog.size() !== 1 || blog[0].we !== 1'b1) begin
      failures++; $display("FAIL prio_flush: bus cycles=%0d, required 1 write", blog.size());
    end
  endtask

  task automatic test_reset_mid_flush();
    logic [255:0] rd;
    int n;
    drain(); blog.delete();
    do_req(1'b1, 1'b0, 32'h7000, 32'hff, rand256(), 1'b0, rd);
    withhold = 1'b1; flush = 1'b1;
    n = 0;
    while (wb_cyc !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_cyc !== 1'b1) begin failures++; $display("FAIL rstf_start: cyc=%b, required 1", wb_cyc); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin
      failures++; $display("FAIL rstf_drop: cyc=%b stb=%b, required 0 0", wb_cyc, wb_stb);
    end
    rst = 1'b0; withhold = 1'b0;
    @(negedge clk);
    checks++;
    if (idle !== 1'b1) begin failures++; $display("FAIL rstf_idle: idle_o=%b, required 1", idle); end
    repeat (40) @(negedge clk);
    checks++;
    if (blog.size() !== 0) begin
      failures++; $display("FAIL rstf_discard: bus cycles=%0d, required 0", blog.size());
    end
  endtask

  task automatic test_random();
    logic [255:0] rd;
    logic [31:0]  a, s;
    int k;
    drain();
    for (int i = 0; i < 60; i++) begin
      ack_delay = $urandom_range(0, 3);
      k = $urandom_range(0, 3);
      a = 32'h4000 + 32'(k * 32) + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 2) == 0) begin
        do_req(1'b0, 1'b1, a, 32'h0, 256'h0, 1'b1, rd);
        checks++;
        if (rd !== ref_line(a >> 5)) begin
          failures++; $display("FAIL rand_read addr=%h: %h, required %h", a, rd, ref_line(a >> 5));
        end
      end else begin
        s = $urandom;
        if ($urandom_range(0, 5) == 0) s = 32'h0;
        do_req(1'b1, 1'b0, a, s, rand256(), 1'b1, rd);
      end
      if ($urandom_range(0, 9) == 0) repeat ($urandom_range(1, 25)) @(negedge clk);
    end
    ack_delay = 0;
    drain();
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (mem_line(32'(32'h4000 + j * 32) >> 5) !== ref_line(32'(32'h4000 + j * 32) >> 5)) begin
        failures++;
        $display("FAIL rand_mem line=%0d: %h, required %h", j, mem_line(32'(32'h4000 + j * 32) >> 5),
                 ref_line(32'(32'h4000 + j * 32) >> 5));
      end
    end
  endtask

  task automatic test_bus_stable();
    checks++;
    if (stab_err !== 0) begin
      failures++; $display("FAIL bus_stable: changes while waiting=%0d, required 0", stab_err);
    end
  endtask

  initial begin
    test_reset();
    test_merge_flush();
    test_line_miss();
    test_read_hit();
    test_timeout();
    test_timeout_disabled();
    test_renderer_seq();
    test_priority();
    test_reset_mid_flush();
    test_random();
    test_bus_stable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/gfx256_render_wbm.md
Name: gfx256_render_wbm

Overview:
- Memory-side responder for the renderer's pixel port.
- Accepts the renderer's level-held write/read requests (addr, 32-bit byte select, 256-bit data) and returns a one-cycle ack.
- Merges byte writes to the same 32-byte line in a single write-combining line buffer, flushing to a 256-bit Wishbone master bus on line miss, read, timeout or explicit flush.
- Sits between the renderer and the system memory arbiter.

Parameters:
- TIMEOUT, 16: idle cycles with a dirty buffer before an automatic flush; 0 disables the timeout.
- TW, 8: width of the timeout counter; must satisfy TIMEOUT < 2**TW.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- render_addr_i  in  32  byte address; bits [31:5] select the line.
- render_sel_i  in  32  byte enables within the line.
- render_dat_i  in  256  write data.
- write_i  in  1  write request, level; held until ack.
- read_i  in  1  read request, level; held until ack.
- ack_o  out  1  one-cycle request completion.
- render_dat_o  out  256  read data; valid when ack_o is high for a read.
- flush_i  in  1  force write-back of the buffer; level.
- idle_o  out  1  high when idle, buffer clean and no request pending.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  Wishbone write enable.
- wb_sel_o  out  32  Wishbone byte selects.
- wb_adr_o  out  32  Wishbone address; bits [4:0] always 0.
- wb_dat_o  out  256  Wishbone write data.
- wb_ack_i  in  1  Wishbone acknowledge; ignored while wb_cyc_o is low.
- wb_dat_i  in  256  Wishbone read data.

Behaviour:
- Reset values: all outputs 0; buffer valid=0, byte mask=0, timeout counter=0; state IDLE.
- Reset mid-flush drops wb_cyc_o/wb_stb_o on the next edge and discards dirty data.
- Internal storage: line tag [31:5], 256-bit data, 32-bit dirty mask, valid bit.
  - hit = valid && tag == render_addr_i[31:5].
- States: IDLE, ACK, FLUSH, READ.
- IDLE, write_i=1 and (!valid or hit):
  - For each byte b with render_sel_i[b], buffer byte b <= data byte b; mask |= sel; tag <= addr[31:5].
  - valid <= valid | (sel != 0); go to ACK.
  - sel == 0: buffer untouched, still acked.
- IDLE, write_i=1 and valid && !hit: go to FLUSH, then return to IDLE and re-evaluate, which now loads the line.
- IDLE, read_i=1:
  - If hit: FLUSH first.
  - Otherwise go to READ: wb_cyc_o=wb_stb_o=1, wb_we_o=0, wb_sel_o=all ones, wb_adr_o={addr[31:5],5'b0}.
  - On wb_ack_i: render_dat_o <= wb_dat_i, cyc/stb <= 0, go to ACK.
- write_i and read_i both high: write wins.
- ACK: ack_o=1 for exactly this one cycle. Requests are not sampled in ACK, because the renderer updates addr/data on this edge. Next state IDLE.
- Write latency:
  - Hit/empty: request in IDLE at cycle N, ack_o high in cycle N+1.
  - Back-to-back requests are accepted every 2 cycles.
- FLUSH: wb_cyc_o=wb_stb_o=wb_we_o=1, wb_adr_o={tag,5'b0}, wb_sel_o=mask, wb_dat_o=buffer. On wb_ack_i: cyc/stb/we <= 0, valid <= 0, mask <= 0, go to IDLE.
- Timeout counter:
  - Counts in IDLE while valid and no request; clears on any merge or flush.
  - When it equals TIMEOUT (TIMEOUT != 0), go to FLUSH.
- flush_i in IDLE with valid and no request: go to FLUSH. Pending requests take priority over flush_i/timeout. flush_i with an empty buffer does nothing.
- idle_o = (state==IDLE) && !valid && !write_i && !read_i.
- Wishbone bus signals are held stable until wb_ack_i; there is never more than one outstanding bus cycle.

Test Plan:
1. Writes to 0x1000 sel=0x0000000F and 0x1004 sel=0x000000F0 → two acks, no bus cycle. Then flush_i → one write: adr=0x1000, sel=0x000000FF, merged data.
2. Write 0x1000 sel=0x1, then write 0x2000 → bus write to 0x1000 sel=0x1 precedes ack of the second write; buffer tag becomes 0x2000>>5.
3. Dirty line 0x3000, read 0x3008 → flush write to 0x3000 then read at 0x3000 sel=0xFFFFFFFF. With wb_dat_i=pattern P, render_dat_o=P when ack_o=1.
4. TIMEOUT=16, single write then no requests → bus write starts exactly 17 cycles after ack (16 idle counts plus the transition); TIMEOUT=0 → no write ever.
5. Renderer-style sequence: write held high across pixel then z-address, wb_ack_i delayed 3 cycles → exactly two acks, no double-ack, z data at its own line.
6. rst_i asserted during FLUSH with wb_ack_i withheld → next cycle wb_cyc_o=0, idle_o=1 once requests are low, and no write-back after reset.
